ctrl_ajuste_minutos: RTL and testbench
======================================

Name: ctrl_ajuste_minutos

Overview:
Upstream control stage for the minutes counter; converts raw adjust buttons into the one-cycle enmin/upmin/downmin commands that counter consumes.
- Synchronizes and debounces two push-buttons (up, down).
- Emits one step per press, plus auto-repeat while a button is held.
- Commands are gated by the adjust-mode input, so minutes change only in set mode.

Parameters:
DEB_CNT, 500000, consecutive stable synchronized samples required to accept a new button level (10 ms at 50 MHz)
RPT_DELAY, 25000000, cycles from first step to first repeat step (0.5 s)
RPT_PERIOD, 5000000, cycles between subsequent repeat steps (0.1 s)
CNT_W, 25, width of the shared timing counters; must hold max(DEB_CNT, RPT_DELAY, RPT_PERIOD)

Ports:
clkmin  in  1  system clock, all logic on rising edge
resetmin  in  1  asynchronous, active-high reset
btn_up  in  1  raw asynchronous up button, active-high
btn_down  in  1  raw asynchronous down button, active-high
mode_ajuste  in  1  adjust mode; 0 blocks all steps
enmin  out  1  one-cycle step strobe to minutes counter
upmin  out  1  step direction up; valid only with enmin
downmin  out  1  step direction down; valid only with enmin
hold  out  1  high while a step sequence is active (PRESS/WAIT_RPT/REPEAT)

Behaviour:
- Reset: resetmin asynchronous, active-high; clock clkmin. During reset:
  - enmin, upmin, downmin and hold = 0.
  - Synchronizer flops and debounced levels = 0; FSM = IDLE; counters = 0.
- Synchronizer: 2 flops per button.
- Debounce, per button:
  - Counter resets whenever the synchronized level equals the debounced level, or whenever it changes.
  - The debounced level flips after DEB_CNT consecutive cycles of differing level.
  - Glitches shorter than DEB_CNT cycles are ignored.
- Latency: a clean raw rising edge gives enmin high exactly 2 + DEB_CNT + 1 cycles later.
- Outputs are registered. enmin is high for exactly 1 cycle per step, with exactly one of upmin/downmin high. upmin and downmin are 0 whenever enmin is 0.
- FSM states:
  - IDLE: on a debounced rising edge of exactly one button with mode_ajuste=1, latch direction, emit a step, go to WAIT_RPT.
  - WAIT_RPT: count RPT_DELAY cycles. At terminal count, emit a step and go to REPEAT. If the latched button is debounced-released, go to IDLE.
  - REPEAT: emit a step every RPT_PERIOD cycles while held. On release go to IDLE.
  - LOCK: entered from any state when both debounced buttons are high. No steps. Return to IDLE only when both are released.
- Direction stays latched for the whole sequence. The second button pressing alone while the first is held counts as "both" and goes to LOCK.
- mode_ajuste=0 in any state: synchronously force IDLE, clear the timing counter, no step that cycle. The debouncers keep running.
- A button already debounced-high when mode_ajuste rises produces no step; a fresh press is required.
- Timing counters never wrap. Each counter clears on every state entry and on every emitted step.
- Reset mid-sequence: outputs drop immediately. A button held through reset release is treated as a new press once DEB_CNT elapses.

Optional Feature:
MIN_AUTOREPEAT_EN
- Defined: WAIT_RPT and REPEAT behave as above.
- Undefined: WAIT_RPT and REPEAT are not built. After the first step the FSM waits in a HELD state until release, giving exactly one step per press. RPT_DELAY and RPT_PERIOD are unused. hold is high in HELD.

Decomposition:
- Package ajuste_pkg holds:
  - FSM state encoding constants (IDLE, WAIT_RPT, REPEAT, LOCK, HELD).
  - Default timing constants for 50 MHz.
  - Direction encoding.
- Sub-module debounce_btn (synchronizer + debounce counter, parameter DEB_CNT): inputs clkmin/resetmin/raw, outputs level and rise. Instantiated twice.

Test Plan:
All tests use DEB_CNT=4, RPT_DELAY=20, RPT_PERIOD=5, mode_ajuste=1 unless stated.
1. btn_up clean pulse, 10 cycles wide, starting at cycle 0 -> single enmin+upmin pulse at cycle 7; no other strobes.
2. btn_up held cycles 0-39 (MIN_AUTOREPEAT_EN defined) -> steps at cycles 7, 27, 32, 37, 42; none after the debounced release; hold falls after release.
3. btn_down toggling 1/0 every 2 cycles for 20 cycles, then low -> no enmin at any time.
4. btn_up held, btn_down pressed 10 cycles later -> one up step at 7, then LOCK with no steps. Release both, then press btn_down -> one downmin step 7 cycles after its press.
5. mode_ajuste=0 while btn_up pressed -> no steps. mode_ajuste raised while still held -> no step. Release and re-press -> step 7 cycles after re-press.
6. resetmin pulsed during REPEAT -> enmin, upmin, downmin and hold go to 0 within the same cycle. With MIN_AUTOREPEAT_EN undefined, a 40-cycle hold yields exactly one step.

Source files
------------

// File: rtl/ajuste_pkg.sv
// Shared state/direction types and 50 MHz timing defaults for the minutes
// adjust control (ctrl_ajuste_minutos and its debounce_btn instances).
package ajuste_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RPT = 3'd1,
        REPEAT   = 3'd2,
        LOCK     = 3'd3,
        HELD     = 3'd4
    } ajuste_state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam int unsigned DEB_CNT_DEF    = 500000;
    localparam int unsigned RPT_DELAY_DEF  = 25000000;
    localparam int unsigned RPT_PERIOD_DEF = 5000000;
    localparam int unsigned CNT_W_DEF      = 25;

    // Largest count any timing counter may have to represent.
    function automatic int unsigned longest_count(input int unsigned a,
                                                  input int unsigned b,
                                                  input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/debounce_btn.sv
// Two-flop synchronizer plus stability counter for one raw push-button;
// level is the debounced state, rise a one-cycle pulse when it goes high.
module debounce_btn
    import ajuste_pkg::*;
#(
    parameter int unsigned DEB_CNT = DEB_CNT_DEF
) (
    input  logic clkmin,
    input  logic resetmin,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned DW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;

    logic          sync1;
    logic          sync2;
    logic [DW-1:0] cnt;

    always_ff @(posedge clkmin or posedge resetmin) begin
        if (resetmin) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            // Any sample that agrees with the accepted level restarts the count,
            // so only an unbroken run of DEB_CNT differing samples flips it.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == DW'(DEB_CNT - 1)) begin
                cnt   <= '0;
                level <= sync2;
                rise  <= sync2;
            end else begin
                cnt <= cnt + DW'(1);
            end
        end
    end

endmodule

// File: rtl/ctrl_ajuste_minutos.sv
// Turns the up/down adjust buttons into enmin/upmin/downmin step strobes.
// Define MIN_AUTOREPEAT_EN to build auto-repeat; otherwise one step per press.
module ctrl_ajuste_minutos
    import ajuste_pkg::*;
#(
    parameter int unsigned DEB_CNT    = DEB_CNT_DEF,
    parameter int unsigned RPT_DELAY  = RPT_DELAY_DEF,
    parameter int unsigned RPT_PERIOD = RPT_PERIOD_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic clkmin,
    input  logic resetmin,
    input  logic btn_up,
    input  logic btn_down,
    input  logic mode_ajuste,
    output logic enmin,
    output logic upmin,
    output logic downmin,
    output logic hold
);

    if ($clog2(longest_count(DEB_CNT, RPT_DELAY, RPT_PERIOD) + 1) > CNT_W) begin : g_cnt_w_too_small
        $error("ctrl_ajuste_minutos: CNT_W too narrow for the configured timing counts");
    end

    logic lvl_up;
    logic rise_up;
    logic lvl_dn;
    logic rise_dn;

    debounce_btn #(
        .DEB_CNT (DEB_CNT)
    ) u_deb_up (
        .clkmin   (clkmin),
        .resetmin (resetmin),
        .raw      (btn_up),
        .level    (lvl_up),
        .rise     (rise_up)
    );

    debounce_btn #(
        .DEB_CNT (DEB_CNT)
    ) u_deb_down (
        .clkmin   (clkmin),
        .resetmin (resetmin),
        .raw      (btn_down),
        .level    (lvl_dn),
        .rise     (rise_dn)
    );

    ajuste_state_t state;
    ajuste_state_t state_nx;
    dir_t          dir;
    dir_t          dir_nx;
    logic          step;
    logic          hold_nx;
    logic          lat_lvl;
`ifdef MIN_AUTOREPEAT_EN
    logic [CNT_W-1:0] tmr;
    logic [CNT_W-1:0] tmr_nx;
`endif

    assign lat_lvl = (dir == DIR_UP) ? lvl_up : lvl_dn;
    assign hold_nx = (state_nx == WAIT_RPT) || (state_nx == REPEAT) || (state_nx == HELD);

    always_ff @(posedge clkmin or posedge resetmin) begin
        if (resetmin) begin
            state   <= IDLE;
            dir     <= DIR_UP;
            enmin   <= 1'b0;
            upmin   <= 1'b0;
            downmin <= 1'b0;
            hold    <= 1'b0;
`ifdef MIN_AUTOREPEAT_EN
            tmr     <= '0;
`endif
        end else begin
            state   <= state_nx;
            dir     <= dir_nx;
            enmin   <= step;
            upmin   <= step && (dir_nx == DIR_UP);
            downmin <= step && (dir_nx == DIR_DOWN);
            hold    <= hold_nx;
`ifdef MIN_AUTOREPEAT_EN
            tmr     <= tmr_nx;
`endif
        end
    end

    // Leaving adjust mode beats everything, then the both-buttons lock;
    // only after that does the per-state sequencing apply.
    always_comb begin
        state_nx = state;
        dir_nx   = dir;
        step     = 1'b0;
`ifdef MIN_AUTOREPEAT_EN
        tmr_nx   = tmr;
`endif
        if (!mode_ajuste) begin
            state_nx = IDLE;
`ifdef MIN_AUTOREPEAT_EN
            tmr_nx   = '0;
`endif
        end else if (lvl_up && lvl_dn) begin
            state_nx = LOCK;
`ifdef MIN_AUTOREPEAT_EN
            tmr_nx   = '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (rise_up || rise_dn) begin
                        step   = 1'b1;
                        dir_nx = rise_up ? DIR_UP : DIR_DOWN;
`ifdef MIN_AUTOREPEAT_EN
                        state_nx = WAIT_RPT;
                        tmr_nx   = '0;
`else
                        state_nx = HELD;
`endif
                    end
                end
`ifdef MIN_AUTOREPEAT_EN
                // Release is checked before the terminal count so a step
                // never fires on the cycle the button is seen released.
                WAIT_RPT: begin
                    if (!lat_lvl) begin
                        state_nx = IDLE;
                        tmr_nx   = '0;
                    end else if (tmr == CNT_W'(RPT_DELAY - 1)) begin
                        step     = 1'b1;
                        state_nx = REPEAT;
                        tmr_nx   = '0;
                    end else begin
                        tmr_nx = tmr + CNT_W'(1);
                    end
                end
                REPEAT: begin
                    if (!lat_lvl) begin
                        state_nx = IDLE;
                        tmr_nx   = '0;
                    end else if (tmr == CNT_W'(RPT_PERIOD - 1)) begin
                        step   = 1'b1;
                        tmr_nx = '0;
                    end else begin
                        tmr_nx = tmr + CNT_W'(1);
                    end
                end
`endif
                HELD: begin
                    if (!lat_lvl) state_nx = IDLE;
                end
                LOCK: begin
                    if (!lvl_up && !lvl_dn) state_nx = IDLE;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_ajuste_minutos.sv
// Self-checking bench for ctrl_ajuste_minutos with DEB_CNT=4, RPT_DELAY=20, RPT_PERIOD=5;
// expected strobes come from a press-list model, repeats only when MIN_AUTOREPEAT_EN is defined.
module tb_ctrl_ajuste_minutos;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 5;
    localparam int NC  = 512;

    logic clkmin = 1'b0;
    logic resetmin;
    logic btn_up;
    logic btn_down;
    logic mode_ajuste;
    logic enmin;
    logic upmin;
    logic downmin;
    logic hold;

    int checks = 0;
    int passed = 0;

    logic       stim_up   [NC];
    logic       stim_dn   [NC];
    logic       stim_mode [NC];
    logic [3:0] exp_obs   [NC];

    ctrl_ajuste_minutos #(
        .DEB_CNT    (DEB),
        .RPT_DELAY  (RD),
        .RPT_PERIOD (RP),
        .CNT_W      (25)
    ) dut (
        .clkmin      (clkmin),
        .resetmin    (resetmin),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .mode_ajuste (mode_ajuste),
        .enmin       (enmin),
        .upmin       (upmin),
        .downmin     (downmin),
        .hold        (hold)
    );

    always #5 clkmin = ~clkmin;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clear_model();
        for (int t = 0; t < NC; t++) begin
            stim_up[t]   = 1'b0;
            stim_dn[t]   = 1'b0;
            stim_mode[t] = 1'b1;
            exp_obs[t]   = 4'b0000;
        end
    endtask

    task automatic mark_step(input int t, input bit is_up);
        if (t < NC) exp_obs[t][3:1] = is_up ? 3'b110 : 3'b101;
    endtask

    // A clean press of L cycles starting at s: first step DEB+3 cycles later,
    // button seen released (and hold dropped) L+DEB+3 cycles after s.
    task automatic add_press(input bit is_up, input int s, input int len, input bit with_stim);
        int first;
        int last;
        if (with_stim) begin
            for (int t = s; t < s + len && t < NC; t++) begin
                if (is_up) stim_up[t] = 1'b1;
                else       stim_dn[t] = 1'b1;
            end
        end
        if (len >= DEB) begin
            first = s + DEB + 3;
            last  = s + len + DEB + 2;
            mark_step(first, is_up);
`ifdef MIN_AUTOREPEAT_EN
            for (int t = first + RD; t <= last; t += RP) mark_step(t, is_up);
`endif
            for (int t = first; t <= last && t < NC; t++) exp_obs[t][0] = 1'b1;
        end
    endtask

    task automatic tick(input int t, output logic [3:0] obs);
        @(negedge clkmin);
        obs         = {enmin, upmin, downmin, hold};
        btn_up      = stim_up[t];
        btn_down    = stim_dn[t];
        mode_ajuste = stim_mode[t];
    endtask

    task automatic do_reset();
        resetmin    = 1'b1;
        btn_up      = 1'b0;
        btn_down    = 1'b0;
        mode_ajuste = 1'b1;
        repeat (2) @(negedge clkmin);
        resetmin = 1'b0;
    endtask

    task automatic test_reset();
        resetmin    = 1'b1;
        btn_up      = 1'($urandom_range(0, 1));
        btn_down    = 1'($urandom_range(0, 1));
        mode_ajuste = 1'b1;
        repeat (3) @(negedge clkmin);
        checks++;
        if (enmin !== 1'b0) $display("[TB] FAIL reset_enmin got %b want 0", enmin);
        else passed++;
        checks++;
        if (upmin !== 1'b0) $display("[TB] FAIL reset_upmin got %b want 0", upmin);
        else passed++;
        checks++;
        if (downmin !== 1'b0) $display("[TB] FAIL reset_downmin got %b want 0", downmin);
        else passed++;
        checks++;
        if (hold !== 1'b0) $display("[TB] FAIL reset_hold got %b want 0", hold);
        else passed++;
        do_reset();
    endtask

    task automatic test_single_pulse();
        logic [3:0] obs;
        do_reset();
        clear_model();
        add_press(1'b1, 0, 10, 1'b1);
        for (int t = 0; t < 30; t++) begin
            tick(t, obs);
            checks++;
            if (obs !== exp_obs[t])
                $display("[TB] FAIL single_pulse t=%0d en/up/dn/hold got %b want %b", t, obs, exp_obs[t]);
            else passed++;
        end
    endtask

    task automatic test_autorepeat_hold();
        logic [3:0] obs;
        do_reset();
        clear_model();
        add_press(1'b1, 0, 40, 1'b1);
        for (int t = 0; t < 60; t++) begin
            tick(t, obs);
            checks++;
            if (obs !== exp_obs[t])
                $display("[TB] FAIL autorepeat_hold t=%0d en/up/dn/hold got %b want %b", t, obs, exp_obs[t]);
            else passed++;
        end
    endtask

    task automatic test_glitch();
        logic [3:0] obs;
        do_reset();
        clear_model();
        for (int k = 0; k < 5; k++) add_press(1'b0, 4 * k, 2, 1'b1);
        for (int t = 0; t < 40; t++) begin
            tick(t, obs);
            checks++;
            if (obs !== exp_obs[t])
                $display("[TB] FAIL glitch t=%0d en/up/dn/hold got %b want %b", t, obs, exp_obs[t]);
            else passed++;
        end
    endtask

    task automatic test_lock();
        logic [3:0] obs;
        do_reset();
        clear_model();
        for (int t = 0; t < 40; t++) stim_up[t] = 1'b1;
        for (int t = 10; t < 40; t++) stim_dn[t] = 1'b1;
        mark_step(DEB + 3, 1'b1);
        for (int t = DEB + 3; t <= 10 + DEB + 2; t++) exp_obs[t][0] = 1'b1;
        add_press(1'b0, 60, 10, 1'b1);
        for (int t = 0; t < 85; t++) begin
            tick(t, obs);
            checks++;
            if (obs !== exp_obs[t])
                $display("[TB] FAIL lock t=%0d en/up/dn/hold got %b want %b", t, obs, exp_obs[t]);
            else passed++;
        end
    endtask

    task automatic test_mode_gate();
        logic [3:0] obs;
        do_reset();
        clear_model();
        for (int t = 0; t < 30; t++) stim_mode[t] = 1'b0;
        for (int t = 0; t < 40; t++) stim_up[t] = 1'b1;
        add_press(1'b1, 50, 10, 1'b1);
        for (int t = 80; t < 110; t++) stim_up[t] = 1'b1;
        for (int t = 95; t < 100; t++) stim_mode[t] = 1'b0;
        mark_step(80 + DEB + 3, 1'b1);
        for (int t = 80 + DEB + 3; t <= 95; t++) exp_obs[t][0] = 1'b1;
        for (int t = 0; t < 130; t++) begin
            tick(t, obs);
            checks++;
            if (obs !== exp_obs[t])
                $display("[TB] FAIL mode_gate t=%0d en/up/dn/hold got %b want %b", t, obs, exp_obs[t]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] obs;
        do_reset();
        clear_model();
        add_press(1'b1, 0, 8, 1'b1);
        add_press(1'b0, 8 + DEB, 8, 1'b1);
        add_press(1'b1, 16 + 2 * DEB, DEB, 1'b1);
        add_press(1'b0, 40, DEB - 1, 1'b1);
        for (int t = 0; t < 60; t++) begin
            tick(t, obs);
            checks++;
            if (obs !== exp_obs[t])
                $display("[TB] FAIL back_to_back t=%0d en/up/dn/hold got %b want %b", t, obs, exp_obs[t]);
            else passed++;
        end
    endtask

    task automatic test_reset_midseq();
        logic [3:0] obs;
        do_reset();
        clear_model();
        add_press(1'b1, 0, 70, 1'b1);
        for (int t = 33; t < NC; t++) exp_obs[t] = 4'b0000;
        add_press(1'b1, 35, 35, 1'b0);
        for (int t = 0; t <= 32; t++) begin
            tick(t, obs);
            checks++;
            if (obs !== exp_obs[t])
                $display("[TB] FAIL reset_midseq t=%0d en/up/dn/hold got %b want %b", t, obs, exp_obs[t]);
            else passed++;
        end
        resetmin = 1'b1;
        #1;
        checks++;
        if ({enmin, upmin, downmin, hold} !== 4'b0000)
            $display("[TB] FAIL reset_async_drop en/up/dn/hold got %b want 0000", {enmin, upmin, downmin, hold});
        else passed++;
        for (int t = 33; t < 90; t++) begin
            tick(t, obs);
            if (t == 35) resetmin = 1'b0;
            checks++;
            if (obs !== exp_obs[t])
                $display("[TB] FAIL reset_midseq t=%0d en/up/dn/hold got %b want %b", t, obs, exp_obs[t]);
            else passed++;
        end
    endtask

    task automatic test_random_presses();
        logic [3:0] obs;
        int s;
        int len;
        bit is_up;
        for (int round = 0; round < 3; round++) begin
            do_reset();
            clear_model();
            s = 0;
            for (int p = 0; p < 5; p++) begin
                len   = int'($urandom_range(1, 45));
                is_up = 1'($urandom_range(0, 1));
                add_press(is_up, s, len, 1'b1);
                s = s + len + int'($urandom_range(DEB, DEB + 10));
            end
            for (int t = 0; t < s + 20; t++) begin
                tick(t, obs);
                checks++;
                if (obs !== exp_obs[t])
                    $display("[TB] FAIL random r=%0d t=%0d en/up/dn/hold got %b want %b", round, t, obs, exp_obs[t]);
                else passed++;
            end
        end
    endtask

    initial begin
        resetmin    = 1'b1;
        btn_up      = 1'b0;
        btn_down    = 1'b0;
        mode_ajuste = 1'b1;
        clear_model();
        test_reset();
        test_single_pulse();
        test_autorepeat_hold();
        test_glitch();
        test_lock();
        test_mode_gate();
        test_back_to_back();
        test_reset_midseq();
        test_random_presses();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
